// File: rtl/bram_arb_pkg.sv
// Shared types for the single-port BRAM arbiter: FSM state encoding and a
// small modulo-increment helper used for the round-robin pointer.
package bram_arb_pkg;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // Returns (value + 1) mod modulus for pointer advancement.
  function automatic int unsigned wrapInc(input int unsigned value,
                                          input int unsigned modulus);
    return (value + 1 >= modulus) ? 0 : value + 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first asserted request found
// searching upward from ptr_i, wrapping modulo NUM_REQ.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [PTR_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [PTR_W-1:0]   grant_idx_o,
  output logic               grant_valid_o
);

  always_comb begin
    int  idx;
    logic found;
    idx           = 0;
    found         = 1'b0;
    grant_o       = '0;
    grant_idx_o   = '0;
    grant_valid_o = 1'b0;
    for (int off = 0; off < NUM_REQ; off++) begin
      idx = (int'(ptr_i) + off) % NUM_REQ;
      if (!found && req_i[idx]) begin
        found         = 1'b1;
        grant_o[idx]  = 1'b1;
        grant_idx_o   = PTR_W'(idx);
        grant_valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bram_sp_arbiter.sv
// Shares one single-port synchronous RAM between NUM_REQ valid/ready clients.
// Clears the whole RAM to INIT_VALUE after reset, then arbitrates round-robin.
module bram_sp_arbiter
  import bram_arb_pkg::*;
#(
  parameter int                    DATA_WIDTH    = 8,
  parameter int                    ADDRESS_WIDTH = 10,
  parameter int                    NUM_REQ       = 4,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE    = '0
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [NUM_REQ-1:0]                 req_valid,
  output logic [NUM_REQ-1:0]                 req_ready,
  input  logic [NUM_REQ-1:0]                 req_we,
  input  logic [NUM_REQ*ADDRESS_WIDTH-1:0]   req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]      req_wdata,
  output logic [NUM_REQ-1:0]                 rsp_valid,
  output logic [DATA_WIDTH-1:0]              rsp_rdata,
  output logic                               init_done,
  output logic                               ram_we,
  output logic [ADDRESS_WIDTH-1:0]           ram_addr,
  output logic [DATA_WIDTH-1:0]              ram_wdata,
  input  logic [DATA_WIDTH-1:0]              ram_rdata
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [ADDRESS_WIDTH-1:0] ADDR_MAX = {ADDRESS_WIDTH{1'b1}};

  state_e                   state_q, state_d;
  logic [ADDRESS_WIDTH-1:0] init_cnt_q, init_cnt_d;
  logic [PTR_W-1:0]         rr_ptr_q, rr_ptr_d;
  logic [NUM_REQ-1:0]       rsp_valid_q, rsp_valid_d;
  logic                     init_done_q, init_done_d;

  logic [NUM_REQ-1:0]       grant;
  logic [PTR_W-1:0]         grant_idx;
  logic                     grant_valid;

  logic                     sel_we;
  logic [ADDRESS_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0]    sel_wdata;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_rr_arbiter (
    .req_i         (req_valid),
    .ptr_i         (rr_ptr_q),
    .grant_o       (grant),
    .grant_idx_o   (grant_idx),
    .grant_valid_o (grant_valid)
  );

  // One-hot AND-OR payload mux keyed on the arbiter grant.
  always_comb begin
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sel_we    = sel_we | (req_we[i] & grant[i]);
      sel_addr  = sel_addr  | (req_addr[i*ADDRESS_WIDTH +: ADDRESS_WIDTH]
                               & {ADDRESS_WIDTH{grant[i]}});
      sel_wdata = sel_wdata | (req_wdata[i*DATA_WIDTH +: DATA_WIDTH]
                               & {DATA_WIDTH{grant[i]}});
    end
  end

  always_comb begin
    state_d     = state_q;
    init_cnt_d  = init_cnt_q;
    init_done_d = init_done_q;
    rr_ptr_d    = rr_ptr_q;
    rsp_valid_d = '0;
    req_ready   = '0;
    ram_we      = 1'b0;
    ram_addr    = '0;
    ram_wdata   = '0;

    case (state_q)
      ST_INIT: begin
        ram_we    = 1'b1;
        ram_addr  = init_cnt_q;
        ram_wdata = INIT_VALUE;
        if (init_cnt_q == ADDR_MAX) begin
          state_d     = ST_RUN;
          init_done_d = 1'b1;
        end else begin
          init_cnt_d = init_cnt_q + 1'b1;
        end
      end

      ST_RUN: begin
        req_ready = grant;
        if (grant_valid) begin
          ram_we      = sel_we;
          ram_addr    = sel_addr;
          ram_wdata   = sel_wdata;
          rr_ptr_d    = PTR_W'(wrapInc(int'(grant_idx), NUM_REQ));
          // Only reads produce a response, one cycle after the handshake.
          rsp_valid_d = grant & {NUM_REQ{~sel_we}};
        end
      end

      default: begin
        state_d = ST_INIT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_INIT;
      init_cnt_q  <= '0;
      init_done_q <= 1'b0;
      rr_ptr_q    <= '0;
      rsp_valid_q <= '0;
    end else begin
      state_q     <= state_d;
      init_cnt_q  <= init_cnt_d;
      init_done_q <= init_done_d;
      rr_ptr_q    <= rr_ptr_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = ram_rdata;
  assign init_done = init_done_q;

endmodule

// File: tb/tb_bram_sp_arbiter.sv
// Directed self-checking bench for bram_sp_arbiter with a behavioural
// single-port synchronous RAM attached to the ram_* pins.
module tb_bram_sp_arbiter;

  localparam int DW = 8;
  localparam int AW = 4;
  localparam int NR = 4;
  localparam logic [DW-1:0] INITV = 8'hA5;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NR-1:0]     req_valid;
  logic [NR-1:0]     req_ready;
  logic [NR-1:0]     req_we;
  logic [NR*AW-1:0]  req_addr;
  logic [NR*DW-1:0]  req_wdata;
  logic [NR-1:0]     rsp_valid;
  logic [DW-1:0]     rsp_rdata;
  logic              init_done;
  logic              ram_we;
  logic [AW-1:0]     ram_addr;
  logic [DW-1:0]     ram_wdata;
  logic [DW-1:0]     ram_rdata;

  logic [DW-1:0]     mem [2**AW];

  int checkCount = 0;
  int failCount  = 0;

  bram_sp_arbiter #(
    .DATA_WIDTH    (DW),
    .ADDRESS_WIDTH (AW),
    .NUM_REQ       (NR),
    .INIT_VALUE    (INITV)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .init_done (init_done),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata)
  );

  always #5 clk = ~clk;

  // Read-first single-port RAM with one-cycle registered read.
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic applyStimulus(input int idx, input logic valid, input logic we,
                               input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
    req_valid[idx]          = valid;
    req_we[idx]             = we;
    req_addr[idx*AW +: AW]  = addr;
    req_wdata[idx*DW +: DW] = wdata;
  endtask

  task automatic stepClock();
    @(posedge clk);
    #1;
  endtask

  task automatic clearAll();
    req_valid = '0;
    req_we    = '0;
    req_addr  = '0;
    req_wdata = '0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    clearAll();
    // Requests held during reset and the sweep must never be accepted.
    for (int i = 0; i < NR; i++) applyStimulus(i, 1'b1, 1'b0, AW'(i), '0);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_init_done", 32'(init_done), 0);
    checkOutput("reset_rsp_valid", 32'(rsp_valid), 0);
    checkOutput("reset_req_ready", 32'(req_ready), 0);
    checkOutput("reset_ram_addr",  32'(ram_addr), 0);
    rst_n = 1'b1;

    for (int k = 0; k < 2**AW; k++) begin
      #1;
      checkOutput("sweep_ram_we",    32'(ram_we), 1);
      checkOutput("sweep_ram_addr",  32'(ram_addr), 32'(k));
      checkOutput("sweep_ram_wdata", 32'(ram_wdata), 32'(INITV));
      checkOutput("sweep_req_ready", 32'(req_ready), 0);
      checkOutput("sweep_init_done", 32'(init_done), 0);
      stepClock();
    end
    clearAll();
    #1;
    checkOutput("run_init_done", 32'(init_done), 1);
    checkOutput("run_idle_ready", 32'(req_ready), 0);
    checkOutput("run_idle_ram_we", 32'(ram_we), 0);

    // Back-to-back readback of the cleared array through requester 0.
    for (int a = 0; a < 2**AW; a++) begin
      applyStimulus(0, 1'b1, 1'b0, AW'(a), '0);
      stepClock();
      checkOutput("clear_rsp_valid", 32'(rsp_valid), 1);
      checkOutput("clear_rdata", 32'(rsp_rdata), 32'(INITV));
    end
    clearAll();
    stepClock();
    checkOutput("clear_rsp_idle", 32'(rsp_valid), 0);

    applyStimulus(0, 1'b1, 1'b1, 4'd3, 8'h5C);
    #1;
    checkOutput("wr_ready", 32'(req_ready), 1);
    checkOutput("wr_ram_we", 32'(ram_we), 1);
    checkOutput("wr_ram_addr", 32'(ram_addr), 3);
    checkOutput("wr_ram_wdata", 32'(ram_wdata), 32'h5C);
    stepClock();
    checkOutput("wr_no_rsp", 32'(rsp_valid), 0);
    applyStimulus(0, 1'b1, 1'b0, 4'd3, '0);
    stepClock();
    checkOutput("rd_rsp_valid", 32'(rsp_valid), 1);
    checkOutput("rd_rdata", 32'(rsp_rdata), 32'h5C);
    clearAll();
    stepClock();
    checkOutput("rd_rsp_pulse", 32'(rsp_valid), 0);

    // Give each requester a distinguishable word at its own index.
    for (int i = 0; i < NR; i++) begin
      applyStimulus(i, 1'b1, 1'b1, AW'(i), 8'(8'h10 + i));
      #1;
      checkOutput("seed_ready", 32'(req_ready), 32'(1 << i));
      stepClock();
      clearAll();
    end

    for (int i = 0; i < NR; i++) applyStimulus(i, 1'b1, 1'b0, AW'(i), '0);
    for (int c = 0; c < 6; c++) begin
      #1;
      checkOutput("rr_ready", 32'(req_ready), 32'(1 << (c % NR)));
      stepClock();
      checkOutput("rr_rsp_valid", 32'(rsp_valid), 32'(1 << (c % NR)));
      checkOutput("rr_rdata", 32'(rsp_rdata), 32'(8'h10 + (c % NR)));
    end
    clearAll();
    stepClock();
    checkOutput("rr_rsp_idle", 32'(rsp_valid), 0);

    // Pointer now sits at 2: requester 3 must beat requester 1.
    applyStimulus(1, 1'b1, 1'b0, 4'd1, '0);
    applyStimulus(3, 1'b1, 1'b0, 4'd3, '0);
    #1;
    checkOutput("ptr2_first_ready", 32'(req_ready), 8);
    stepClock();
    checkOutput("ptr2_first_rsp", 32'(rsp_valid), 8);
    checkOutput("ptr2_first_rdata", 32'(rsp_rdata), 32'h13);
    applyStimulus(3, 1'b0, 1'b0, '0, '0);
    #1;
    checkOutput("ptr2_second_ready", 32'(req_ready), 2);
    stepClock();
    checkOutput("ptr2_second_rsp", 32'(rsp_valid), 2);
    checkOutput("ptr2_second_rdata", 32'(rsp_rdata), 32'h11);
    clearAll();

    // A requester-3 transfer wraps the pointer back to 0.
    applyStimulus(3, 1'b1, 1'b0, 4'd3, '0);
    stepClock();
    clearAll();
    applyStimulus(0, 1'b1, 1'b0, 4'd0, '0);
    applyStimulus(1, 1'b1, 1'b0, 4'd1, '0);
    applyStimulus(2, 1'b1, 1'b1, 4'd7, 8'h77);
    #1;
    checkOutput("hold_ready_0", 32'(req_ready), 1);
    stepClock();
    applyStimulus(0, 1'b0, 1'b0, '0, '0);
    #1;
    checkOutput("hold_ready_1", 32'(req_ready), 2);
    stepClock();
    applyStimulus(1, 1'b0, 1'b0, '0, '0);
    #1;
    checkOutput("hold_ready_2", 32'(req_ready), 4);
    checkOutput("hold_ram_we", 32'(ram_we), 1);
    checkOutput("hold_ram_addr", 32'(ram_addr), 7);
    checkOutput("hold_ram_wdata", 32'(ram_wdata), 32'h77);
    stepClock();
    applyStimulus(2, 1'b1, 1'b0, 4'd7, '0);
    stepClock();
    checkOutput("hold_rb_rsp", 32'(rsp_valid), 4);
    checkOutput("hold_rb_rdata", 32'(rsp_rdata), 32'h77);
    clearAll();

    // Reset lands in the cycle that would carry a read response.
    applyStimulus(0, 1'b1, 1'b0, 4'd3, '0);
    stepClock();
    rst_n = 1'b0;
    clearAll();
    #1;
    checkOutput("mid_rst_rsp", 32'(rsp_valid), 0);
    checkOutput("mid_rst_init_done", 32'(init_done), 0);
    checkOutput("mid_rst_ram_addr", 32'(ram_addr), 0);
    stepClock();
    checkOutput("mid_rst_rsp_hold", 32'(rsp_valid), 0);
    rst_n = 1'b1;
    for (int k = 0; k < 2**AW; k++) begin
      #1;
      checkOutput("resweep_addr", 32'(ram_addr), 32'(k));
      checkOutput("resweep_init_done", 32'(init_done), 0);
      checkOutput("resweep_rsp", 32'(rsp_valid), 0);
      stepClock();
    end
    #1;
    checkOutput("resweep_done", 32'(init_done), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
